mem_write_port: RTL and testbench

- Avalon-MM write master with a small posting FIFO.
- Sits beside the memory read port in the bus subsystem.
- Accepts single-word write requests (address + data) from ISP pipeline logic and buffers them.
- Drains the buffer to the Avalon-MM fabric, honouring master_waitrequest.
- Requesters are decoupled from fabric stalls until the FIFO fills.

---
 rtl/mem_write_port_if.sv | 32 +++
 rtl/mem_write_port.sv | 86 ++++++++
 tb/tb_mem_write_port.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_write_port_if.sv
// Bundle of the requester-side and Avalon-MM master-side signals of mem_write_port.
// slave modport: the write port's own view; master modport: whoever drives requests
// and plays the fabric.
interface mem_write_port_if #(
   parameter int DATAWIDTH      = 32,
   parameter int ADDRESSWIDTH   = 20,
   parameter int FIFODEPTH_LOG2 = 3
);
   logic [ADDRESSWIDTH-1:0]   write_addr;
   logic [DATAWIDTH-1:0]      write_data;
   logic                      write;
   logic                      waitrequest;
   logic                      idle;
   logic [FIFODEPTH_LOG2:0]   fill_level;
   logic [ADDRESSWIDTH-1:0]   master_address;
   logic                      master_write;
   logic [DATAWIDTH/8-1:0]    master_byteenable;
   logic [DATAWIDTH-1:0]      master_writedata;
   logic                      master_waitrequest;

   modport slave (
      input  write_addr, write_data, write, master_waitrequest,
      output waitrequest, idle, fill_level,
             master_address, master_write, master_byteenable, master_writedata
   );

   modport master (
      output write_addr, write_data, write, master_waitrequest,
      input  waitrequest, idle, fill_level,
             master_address, master_write, master_byteenable, master_writedata
   );
endinterface

// File: rtl/mem_write_port.sv
// Avalon-MM write master with a small posting FIFO.
// Requests {addr,data} are queued and drained to the fabric in acceptance order.
// All status and master outputs come from registered state only, so nothing on the
// fabric side ever combinationally depends on a requester input (no bypass).
module mem_write_port #(
   parameter int DATAWIDTH      = 32,
   parameter int ADDRESSWIDTH   = 20,
   parameter int FIFODEPTH      = 8,
   parameter int FIFODEPTH_LOG2 = 3
) (
   input  logic            clk,
   input  logic            reset,
   mem_write_port_if.slave bus
);
   localparam int ENTRYW = ADDRESSWIDTH + DATAWIDTH;
   localparam logic [FIFODEPTH_LOG2:0] FULL_COUNT = (FIFODEPTH_LOG2+1)'(FIFODEPTH);

   logic [ENTRYW-1:0]         mem_q [FIFODEPTH];
   logic [FIFODEPTH_LOG2-1:0] wp_q, wp_d;
   logic [FIFODEPTH_LOG2-1:0] rp_q, rp_d;
   logic [FIFODEPTH_LOG2:0]   count_q, count_d;
   logic                      full;
   logic                      not_empty;
   logic                      push;
   logic                      pop;
   logic [ENTRYW-1:0]         head;

   // Full/empty flags from the registered count; a pop in the same cycle does not
   // free a slot until the next edge.
   always_comb begin
      full      = (count_q == FULL_COUNT);
      not_empty = (count_q != '0);
   end

   // Handshake qualification and next pointer/count values.
   always_comb begin
      push    = bus.write & ~full;
      pop     = not_empty & ~bus.master_waitrequest;
      wp_d    = wp_q;
      rp_d    = rp_q;
      count_d = count_q;
      if (push) begin
         wp_d = wp_q + 1'b1;
      end
      if (pop) begin
         rp_d = rp_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pointer and count registers; reset discards every buffered entry at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wp_q    <= '0;
         rp_q    <= '0;
         count_q <= '0;
      end else begin
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         count_q <= count_d;
      end
   end

   // Entry storage; contents are never cleared, count alone says what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wp_q] <= {bus.write_addr, bus.write_data};
      end
   end

   // Requester status and Avalon master outputs, all from registered state.
   always_comb begin
      head                  = mem_q[rp_q];
      bus.waitrequest       = full;
      bus.idle              = ~not_empty;
      bus.fill_level        = count_q;
      bus.master_write      = not_empty;
      bus.master_address    = head[ENTRYW-1:DATAWIDTH];
      bus.master_writedata  = head[DATAWIDTH-1:0];
      bus.master_byteenable = '1;
   end
endmodule

// File: tb/tb_mem_write_port.sv
// Bench for mem_write_port: directed scenarios plus random traffic, checked by a
// queue-based reference model. The recorder pushes each accepted request into the
// scoreboard; the monitor compares every fabric write against the queue head.
module tb_mem_write_port;
   localparam int DW    = 32;
   localparam int AW    = 20;
   localparam int DEPTH = 8;
   localparam int LOG2  = 3;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   mem_write_port_if #(.DATAWIDTH(DW), .ADDRESSWIDTH(AW), .FIFODEPTH_LOG2(LOG2)) bus ();

   mem_write_port #(
      .DATAWIDTH(DW), .ADDRESSWIDTH(AW), .FIFODEPTH(DEPTH), .FIFODEPTH_LOG2(LOG2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int tests_run    = 0;
   int tests_failed = 0;
   logic [AW+DW-1:0] sb [$];
   bit   push_now    = 1'b0;
   int   pushes_seen = 0;
   int   pops_seen   = 0;
   int   max_fill    = 0;
   bit   toggling    = 1'b0;
   bit   rnd_stall   = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a request is taken whenever it is presented and fewer than
   // DEPTH entries are outstanding.
   always @(negedge clk) begin
      push_now = 1'b0;
      if (reset && bus.write && sb.size() < DEPTH) begin
         sb.push_back({bus.write_addr, bus.write_data});
         push_now = 1'b1;
         pushes_seen++;
      end
   end

   // Monitor: status against the model, each fabric write against the queue head.
   always @(negedge clk) begin
      int m;
      #1;
      if (reset) begin
         m = sb.size() - (push_now ? 1 : 0);
         if (int'(bus.fill_level) > max_fill) max_fill = int'(bus.fill_level);
         check("fill_level",   64'(bus.fill_level),       64'(m));
         check("waitrequest",  64'(bus.waitrequest),      64'(m == DEPTH));
         check("idle",         64'(bus.idle),             64'(m == 0));
         check("master_write", 64'(bus.master_write),     64'(m != 0));
         check("byteenable",   64'(bus.master_byteenable), 64'hF);
         if (m > 0 && !bus.master_waitrequest) begin
            check("write_order", 64'({bus.master_address, bus.master_writedata}), 64'(sb[0]));
            void'(sb.pop_front());
            pops_seen++;
         end
      end
   end

   // Present a request (called just after a rising edge) and hold it until taken.
   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      int n = 0;
      bus.write_addr = a;
      bus.write_data = d;
      bus.write      = 1'b1;
      @(negedge clk);
      while (bus.waitrequest && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         tests_run++;
         tests_failed++;
         $display("FAIL accept_timeout: request addr 0x%0h never accepted", a);
      end
      @(posedge clk);
      #1;
      bus.write = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (!(bus.idle && sb.size() == 0) && n < 500) begin
         @(negedge clk);
         n++;
      end
      check(name, 64'(n < 500), 64'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.write_addr         = '0;
      bus.write_data         = '0;
      bus.write              = 1'b0;
      bus.master_waitrequest = 1'b0;

      // 1. reset then idle
      repeat (3) @(posedge clk);
      #1;
      check("rst_master_write", 64'(bus.master_write), 64'd0);
      check("rst_fill_level",   64'(bus.fill_level),   64'd0);
      reset = 1'b1;
      @(negedge clk);
      check("post_rst_waitreq", 64'(bus.waitrequest),       64'd0);
      check("post_rst_idle",    64'(bus.idle),              64'd1);
      check("post_rst_be",      64'(bus.master_byteenable), 64'hF);
      @(posedge clk);
      #1;

      // 2. single write, no stall: visible for exactly one cycle
      bus.write_addr = 20'h00010;
      bus.write_data = 32'hDEADBEEF;
      bus.write      = 1'b1;
      @(negedge clk);
      check("single_no_bypass", 64'(bus.master_write), 64'd0);
      @(posedge clk);
      #1;
      bus.write = 1'b0;
      @(negedge clk);
      check("single_mw",   64'(bus.master_write),     64'd1);
      check("single_addr", 64'(bus.master_address),   64'h00010);
      check("single_data", 64'(bus.master_writedata), 64'hDEADBEEF);
      @(negedge clk);
      check("single_done_mw",   64'(bus.master_write), 64'd0);
      check("single_done_idle", 64'(bus.idle),         64'd1);
      @(posedge clk);
      #1;

      // 3. fill under stall
      bus.master_waitrequest = 1'b1;
      for (int i = 1; i <= 8; i++) do_write(20'(i), 32'(i));
      bus.write_addr = 20'd9;
      bus.write_data = 32'd9;
      bus.write      = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("full_waitreq", 64'(bus.waitrequest),      64'd1);
         check("full_level",   64'(bus.fill_level),       64'd8);
         check("full_head",    64'(bus.master_writedata), 64'd1);
      end

      // 4. drain; waitrequest drops the cycle after the first pop
      @(posedge clk);
      #1;
      bus.master_waitrequest = 1'b0;
      @(negedge clk);
      check("drain_first_waitreq", 64'(bus.waitrequest), 64'd1);
      check("drain_first_head",    64'(bus.master_writedata), 64'd1);
      @(negedge clk);
      check("drain_waitreq_drop",  64'(bus.waitrequest), 64'd0);
      @(posedge clk);
      #1;
      bus.write = 1'b0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         check("drain_streaming", 64'(bus.master_write), 64'd1);
      end
      @(negedge clk);
      check("drain_idle", 64'(bus.idle), 64'd1);
      check("drain_count", 64'(pops_seen), 64'd10);
      @(posedge clk);
      #1;

      // 5. concurrent push/pop with toggling stall, pointers wrap
      toggling = 1'b1;
      bus.master_waitrequest = 1'b1;
      fork
         begin
            while (toggling) begin
               @(posedge clk);
               #1;
               if (toggling) bus.master_waitrequest = ~bus.master_waitrequest;
            end
         end
      join_none
      for (int i = 0; i < 20; i++) do_write(20'(i), 32'(32'hA0 + i));
      toggling = 1'b0;
      bus.master_waitrequest = 1'b0;
      wait_idle("stream_drain");
      check("stream_pushes", 64'(pushes_seen), 64'd30);
      check("stream_pops",   64'(pops_seen),   64'd30);
      check("stream_max_fill_ok", 64'(max_fill <= DEPTH), 64'd1);

      // random traffic with random fabric stalls
      rnd_stall = 1'b1;
      fork
         begin
            while (rnd_stall) begin
               @(posedge clk);
               #1;
               if (rnd_stall) bus.master_waitrequest = ($urandom_range(0, 2) == 0);
            end
         end
      join_none
      for (int i = 0; i < 60; i++) begin
         do_write(20'($urandom), $urandom);
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #1;
         end
      end
      rnd_stall = 1'b0;
      bus.master_waitrequest = 1'b0;
      wait_idle("random_drain");
      check("random_balance", 64'(pops_seen), 64'(pushes_seen));

      // 6. reset mid-operation with buffered entries under stall
      bus.master_waitrequest = 1'b1;
      for (int i = 0; i < 5; i++) do_write(20'(20'h100 + i), 32'(32'h100 + i));
      @(negedge clk);
      check("pre_reset_fill", 64'(bus.fill_level), 64'd5);
      @(posedge clk);
      #2;
      reset = 1'b0;
      sb.delete();
      #1;
      check("async_rst_mw",   64'(bus.master_write), 64'd0);
      check("async_rst_fill", 64'(bus.fill_level),   64'd0);
      check("async_rst_idle", 64'(bus.idle),         64'd1);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      do_write(20'h00055, 32'h55);
      @(negedge clk);
      check("after_rst_mw",   64'(bus.master_write),     64'd1);
      check("after_rst_head", 64'(bus.master_writedata), 64'h55);
      check("after_rst_fill", 64'(bus.fill_level),       64'd1);
      @(posedge clk);
      #1;
      bus.master_waitrequest = 1'b0;
      wait_idle("after_rst_drain");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
